// File: rtl/divide_102x51.sv
// Sequential restoring divider: 102-bit limb-packed dividend by 51-bit divisor,
// valid/ready on both sides. Define DIVIDE_RADIX4_EN to retire two quotient bits per cycle.
module divide_102x51 (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [101:0]   dividend,
  input  logic [50:0]    divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [50:0]    quotient,
  output logic [50:0]    remainder,
  output logic           overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef DIVIDE_RADIX4_EN
  localparam logic [5:0] STEPS = 6'd26;
`else
  localparam logic [5:0] STEPS = 6'd51;
`endif

  state_t       state_reg;
  logic [50:0]  lo_reg;
  logic [50:0]  div_reg;
  logic [50:0]  rem_reg;
  logic [50:0]  quo_reg;
  logic [5:0]   cnt_reg;
  logic         ovf_reg;

  logic         in_ready_reg;
  logic         out_valid_reg;
  logic         overflow_reg;
  logic [50:0]  quotient_reg;
  logic [50:0]  remainder_reg;

  logic [51:0]  s1;
  logic [50:0]  rem_next;
  logic [50:0]  quo_next;
  logic [50:0]  lo_next;
  logic         ovf_in;

  // One restoring step: returns {q bit, new remainder}. r < d on entry keeps the result in 51 bits.
  function automatic logic [51:0] div_step(input logic [50:0] r, input logic b, input logic [50:0] d);
    logic [51:0] t;
    t = {r, b};
    if (t >= {1'b0, d}) begin
      t = t - {1'b0, d};
      return {1'b1, t[50:0]};
    end
    return {1'b0, t[50:0]};
  endfunction

  assign ovf_in = (divisor == 51'd0) || (dividend[101:51] >= divisor);

`ifdef DIVIDE_RADIX4_EN
  logic [51:0] s2;

  always_comb begin
    s1 = div_step(rem_reg, lo_reg[50], div_reg);
    s2 = div_step(s1[50:0], lo_reg[49], div_reg);
    // The first RUN cycle handles the odd bit 50 alone so the rest pairs up evenly.
    if (cnt_reg == STEPS) begin
      rem_next = s1[50:0];
      quo_next = {quo_reg[49:0], s1[51]};
      lo_next  = {lo_reg[49:0], 1'b0};
    end else begin
      rem_next = s2[50:0];
      quo_next = {quo_reg[48:0], s1[51], s2[51]};
      lo_next  = {lo_reg[48:0], 2'b00};
    end
  end
`else
  always_comb begin
    s1       = div_step(rem_reg, lo_reg[50], div_reg);
    rem_next = s1[50:0];
    quo_next = {quo_reg[49:0], s1[51]};
    lo_next  = {lo_reg[49:0], 1'b0};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      lo_reg        <= '0;
      div_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            lo_reg       <= dividend[50:0];
            div_reg      <= divisor;
            rem_reg      <= dividend[101:51];
            quo_reg      <= '0;
            cnt_reg      <= STEPS;
            ovf_reg      <= ovf_in;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          // An overflowed operation spends one RUN cycle so its latency is a single cycle after accept.
          if (ovf_reg) begin
            quotient_reg  <= '1;
            remainder_reg <= '0;
            overflow_reg  <= 1'b1;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg - 6'd1;
            if (cnt_reg == 6'd1) begin
              quotient_reg  <= quo_next;
              remainder_reg <= rem_next;
              overflow_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_divide_102x51.sv
// Directed, table-driven bench for divide_102x51 plus backpressure and mid-run reset sequences.
module tb_divide_102x51;

`ifdef DIVIDE_RADIX4_EN
  localparam int NORM_LAT = 26;
`else
  localparam int NORM_LAT = 51;
`endif
  localparam int TIMEOUT = 200;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [101:0]   dividend;
  logic [50:0]    divisor;
  logic           out_valid;
  logic           out_ready;
  logic [50:0]    quotient;
  logic [50:0]    remainder;
  logic           overflow;

  int checks = 0;
  int failures = 0;

  divide_102x51 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [101:0] dvd;
    logic [50:0]  dvs;
    logic [50:0]  q;
    logic [50:0]  r;
    logic         o;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [101:0] act, input logic [101:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one operation, then count edges after the accepting edge until out_valid is seen.
  task automatic run_op(input logic [101:0] dvd, input logic [50:0] dvs, output int lat,
                        output logic [50:0] q, output logic [50:0] r, output logic o);
    @(negedge clk);
    check("in_ready_before_accept", 102'(in_ready), 102'd1);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~dvd;
    divisor  = ~dvs;
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    o = overflow;
  endtask

  logic [101:0] dmax;
  logic [50:0]  q, r, q0, r0;
  logic         o, o0;
  int           lat;
  int           seen;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;

    dmax = {51'd0, 51'h7FFFFFFFFFFFF};
    vecs[0] = '{102'd100, 51'd7, 51'd14, 51'd2, 1'b0};
    vecs[1] = '{102'h8000000000000, 51'd3, 51'd750599937895082, 51'd2, 1'b0};
    vecs[2] = '{dmax * dmax + dmax - 102'd1, 51'h7FFFFFFFFFFFF, 51'h7FFFFFFFFFFFF, 51'h7FFFFFFFFFFFE, 1'b0};
    vecs[3] = '{102'd5, 51'd0, {51{1'b1}}, 51'd0, 1'b1};
    vecs[4] = '{(102'd9 << 51), 51'd9, {51{1'b1}}, 51'd0, 1'b1};
    vecs[5] = '{(102'd8 << 51) + 102'd5, 51'd9, 51'd2001599834386887, 51'd6, 1'b0};
    vecs[6] = '{102'h7FFFFFFFFFFFF, 51'd1, 51'h7FFFFFFFFFFFF, 51'd0, 1'b0};
    vecs[7] = '{102'h8000000000000, 51'd1, {51{1'b1}}, 51'd0, 1'b1};
    vecs[8] = '{102'd0, 51'd5, 51'd0, 51'd0, 1'b0};

    // Reset state
    #12;
    check("rst_in_ready", 102'(in_ready), 102'd1);
    check("rst_out_valid", 102'(out_valid), 102'd0);
    check("rst_quotient", 102'(quotient), 102'd0);
    check("rst_remainder", 102'(remainder), 102'd0);
    check("rst_overflow", 102'(overflow), 102'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, lat, q, r, o);
      check($sformatf("v%0d_latency", i), 102'(lat), vecs[i].o ? 102'd1 : 102'(NORM_LAT));
      check($sformatf("v%0d_quotient", i), 102'(q), 102'(vecs[i].q));
      check($sformatf("v%0d_remainder", i), 102'(r), 102'(vecs[i].r));
      check($sformatf("v%0d_overflow", i), 102'(o), 102'(vecs[i].o));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_in_ready_return", i), 102'(in_ready), 102'd1);
      $display("vec %0d: dvd=%0d dvs=%0d q=%0d r=%0d ovf=%0d lat=%0d", i, vecs[i].dvd, vecs[i].dvs, q, r, o, lat);
    end

    // Backpressure: result held, no accept while busy
    out_ready = 1'b0;
    run_op(102'd100, 51'd7, lat, q0, r0, o0);
    check("bp_latency", 102'(lat), 102'(NORM_LAT));
    check("bp_quotient", 102'(q0), 102'd14);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      dividend = {$urandom, $urandom, $urandom, 6'($urandom)};
      divisor  = {19'($urandom), $urandom};
      @(posedge clk);
      #1;
      check("bp_out_valid", 102'(out_valid), 102'd1);
      check("bp_in_ready", 102'(in_ready), 102'd0);
      check("bp_quotient_hold", 102'(quotient), 102'd14);
      check("bp_remainder_hold", 102'(remainder), 102'd2);
      check("bp_overflow_hold", 102'(overflow), 102'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 102'(out_valid), 102'd0);
    check("bp_release_in_ready", 102'(in_ready), 102'd1);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) seen++;
    end
    check("bp_no_second_accept", 102'(seen), 102'd0);
    $display("backpressure: q=%0d r=%0d held 10 cycles", q0, r0);

    // Reset during RUN at step 20
    @(negedge clk);
    dividend = 102'd100;
    divisor  = 51'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 102'(in_ready), 102'd1);
    check("midrst_out_valid", 102'(out_valid), 102'd0);
    check("midrst_quotient", 102'(quotient), 102'd0);
    check("midrst_remainder", 102'(remainder), 102'd0);
    check("midrst_overflow", 102'(overflow), 102'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst_no_result", 102'(seen), 102'd0);
    run_op(102'd100, 51'd7, lat, q, r, o);
    check("post_rst_latency", 102'(lat), 102'(NORM_LAT));
    check("post_rst_quotient", 102'(q), 102'd14);
    check("post_rst_remainder", 102'(r), 102'd2);
    check("post_rst_overflow", 102'(o), 102'd0);
    $display("reset mid-run then 100/7: q=%0d r=%0d lat=%0d", q, r, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
